ex_muldiv_ctrl: RTL and testbench
=================================

# ex_muldiv_ctrl

Iterative multiply/divide sequencer for the RV32M extension, attached beside the EX stage ALU of the pipelined core. It accepts one M-type instruction from ID/EX and computes the result over 32 iteration cycles. While it works it stalls IF, ID and EX, then presents the result and destination register to EX/MEM for one cycle. It also handles the RISC-V special cases for divide-by-zero and signed overflow, and supports abort on pipeline flush.

## Interface
Parameters:
- XLEN, 32: operand and result width. Only 32 is supported.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  EX holds a valid M-type op (opcode 0110011, funct7 0000001).
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  32  operand A (forwarded value).
- rs2_data  in  32  operand B (forwarded value).
- rd  in  5  destination register.
- flush  in  1  branch/exception flush; aborts any op in progress.
- ex_stall  out  1  holds the PC, IF/ID and ID/EX registers.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; result and rd_out are valid.
- result  out  32  product or quotient/remainder.
- rd_out  out  5  destination of the completed op.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, with start=1 and flush=0:
  - Latch funct3 and rd.
  - Latch the operand magnitudes: take the absolute value of each operand treated as signed for that op. MULHSU treats rs2 as unsigned; the U ops treat both as unsigned.
  - Latch the negate flags.
  - Clear the 5-bit counter.
- Leaving IDLE:
  - Divide op with rs2=0 -> DONE. result = 0xFFFFFFFF for DIV/DIVU; rs1 for REM/REMU.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF -> DONE. result = 0x80000000 for DIV; 0 for REM.
  - Otherwise -> CALC.
- CALC: one bit per cycle; counter increments each cycle and goes to FIX after count 31.
  - Multiply: 64-bit shift-add.
  - Divide: restoring, 32-bit quotient and remainder.
- FIX:
  - Negate the 64-bit product if the operand signs differ.
  - MUL selects the low word; MULH/MULHSU/MULHU select the high word.
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the dividend's sign.
  - Register result and rd_out; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE. start is ignored in DONE because the same instruction is still presented.
- start is ignored in CALC, FIX and DONE.
- ex_stall = !flush & ((IDLE & start) | CALC | FIX). This is combinational from start and flush. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- flush in any state: next state IDLE, no done pulse. result and rd_out keep their previous values.
- result and rd_out hold their value after done until the next completion.
- Reset: state IDLE, counter 0, internal registers 0. All outputs reset to 0: done, busy, ex_stall (given start=0), result, rd_out.

## Timing
- start sampled at edge N (cycle N).
- Normal op: CALC during cycles N+1..N+32, FIX at N+33, DONE at N+34. done is high in cycle N+34.
- Normal op: ex_stall is high in cycles N..N+33 (34 cycles).
- Special case: DONE at N+1; ex_stall is high only in cycle N.
- A new start can be accepted in the cycle after DONE. Back-to-back ops have zero idle gap beyond DONE.
- flush has priority over start when both are asserted in IDLE. rst has priority over everything.
- Counter wrap: the 31->0 transition occurs only on the CALC->FIX exit. The counter is reloaded on every accept.

## Structure
- Shared package riscv_pkg holds:
  - the funct3 localparams for the M ops;
  - the FSM state encoding (2 bits);
  - the constants DIV0_QUOT (0xFFFFFFFF) and INT_MIN (0x80000000).
- One sub-module, muldiv_datapath, holds the 64-bit accumulator/remainder, the quotient register, the shift/subtract step and the final negation. It is controlled by load/step/fix strobes.
- ex_muldiv_ctrl holds the FSM, the counter, special-case detection, stall generation and the output registers.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD, rd=5, start at N -> ex_stall high N..N+33; done at N+34 with result=0xFFFFFFEB and rd_out=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -20/3 -> 0xFFFFFFFA. REM -20/3 -> 0xFFFFFFFE. DIVU 20/3 -> 6. REMU 20/3 -> 2.
- Special cases, each with done at N+1 and ex_stall high only in cycle N:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- flush in cycle N+10 -> busy=0 and ex_stall=0 from N+11, no done pulse, result unchanged. A new MUL started at N+11 completes at N+45.
- rst asserted in CALC -> next cycle all outputs are 0 and state is IDLE. With start held high through DONE, only one done pulse is produced per accepted op.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 op codes, sequencer state encoding and
// special-case constants used by the iterative multiply/divide unit.
package riscv_pkg;

  localparam int unsigned W       = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ITERS   = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [W-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Operand A is signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
           (f == F3_DIV) || (f == F3_REM);
  endfunction

  // Operand B is signed for MUL, MULH, DIV, REM.
  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude datapath: 64-bit shift-add multiply / restoring divide over
// 32 steps, with sign correction applied on the way out.
module muldiv_datapath
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [2:0]   op,
  input  logic         a_signed,
  input  logic         b_signed,
  input  logic [W-1:0] rs1_data,
  input  logic [W-1:0] rs2_data,
  output logic [W-1:0] res_c
);

  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] divisor;
  logic         a_neg;
  logic         b_neg;

  logic         a_is_neg;
  logic         b_is_neg;
  logic [W:0]   mul_sum;
  logic [W:0]   div_tmp;
  logic         div_ge;
  logic [W-1:0] div_hi;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_s;
  logic [W-1:0] quot_s;
  logic [W-1:0] rem_s;

  assign a_is_neg = a_signed & rs1_data[W-1];
  assign b_is_neg = b_signed & rs2_data[W-1];

  // hi holds the running product high word / partial remainder; lo holds
  // the multiplier being consumed / quotient being built.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : (W+1)'(0));
    div_tmp = {hi, lo[W-1]};
    div_ge  = div_tmp >= {1'b0, divisor};
    div_hi  = div_ge ? (div_tmp[W-1:0] - divisor) : div_tmp[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      divisor <= '0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
    end else if (load) begin
      a_neg   <= a_is_neg;
      b_neg   <= b_is_neg;
      lo      <= a_is_neg ? (W'(0) - rs1_data) : rs1_data;
      divisor <= b_is_neg ? (W'(0) - rs2_data) : rs2_data;
      hi      <= '0;
    end else if (step) begin
      if (op[2]) begin
        hi <= div_hi;
        lo <= {lo[W-2:0], div_ge};
      end else begin
        hi <= mul_sum[W:1];
        lo <= {mul_sum[0], lo[W-1:1]};
      end
    end
  end

  // Sign correction: product by sign difference, quotient likewise,
  // remainder follows the dividend.
  always_comb begin
    prod   = {hi, lo};
    prod_s = (a_neg ^ b_neg) ? ((2*W)'(0) - prod) : prod;
    quot_s = (a_neg ^ b_neg) ? (W'(0) - lo) : lo;
    rem_s  = a_neg ? (W'(0) - hi) : hi;
    res_c  = '0;
    case (op)
      F3_MUL:                      res_c = prod_s[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_c = prod_s[2*W-1:W];
      F3_DIV, F3_DIVU:             res_c = quot_s;
      default:                     res_c = rem_s;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M iterative multiply/divide sequencer beside the EX ALU: stalls the
// front of the pipe while iterating, then presents result/rd for one cycle.
module ex_muldiv_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            ex_stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         f3_q;
  logic [4:0]         rd_q;
  logic               load_c;
  logic               step_c;
  logic               fix_c;
  logic               div0_c;
  logic               ovf_c;
  logic               special_c;
  logic [XLEN-1:0]    special_val_c;
  logic [W-1:0]       res_c;

  // Divide-by-zero and signed overflow finish without iterating.
  always_comb begin
    div0_c        = funct3[2] && (rs2_data == '0);
    ovf_c         = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (rs1_data == INT_MIN) && (rs2_data == '1);
    special_c     = div0_c | ovf_c;
    special_val_c = '0;
    if (div0_c)
      special_val_c = funct3[1] ? rs1_data : DIV0_QUOT;
    else if (ovf_c)
      special_val_c = funct3[1] ? '0 : INT_MIN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_c   = 1'b0;
    step_c   = 1'b0;
    ex_stall = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ex_stall = 1'b1;
          load_c   = 1'b1;
          state_nx = special_c ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        ex_stall = 1'b1;
        step_c   = 1'b1;
        if (cnt == CNT_W'(ITERS - 1)) state_nx = S_FIX;
      end
      S_FIX: begin
        ex_stall = 1'b1;
        state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Flush wins over everything except reset.
    if (flush) begin
      state_nx = S_IDLE;
      load_c   = 1'b0;
      step_c   = 1'b0;
      ex_stall = 1'b0;
    end
  end

  assign fix_c = (state == S_FIX) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      f3_q   <= '0;
      rd_q   <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= (state_nx == S_DONE);
      busy <= (state_nx != S_IDLE);
      if (load_c) begin
        cnt  <= '0;
        f3_q <= funct3;
        rd_q <= rd;
        if (special_c) begin
          result <= special_val_c;
          rd_out <= rd;
        end
      end else if (step_c) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fix_c) begin
        result <= res_c;
        rd_out <= rd_q;
      end
    end
  end

  muldiv_datapath u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .step     (step_c),
    .op       (f3_q),
    .a_signed (op_a_signed(funct3)),
    .b_signed (op_b_signed(funct3)),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .res_c    (res_c)
  );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed RV32M cases plus random ops checked
// against an arithmetic reference, with latency, stall, flush and reset checks.
module tb_ex_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        flush;
  logic        ex_stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_ctrl #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd       (rd),
    .flush    (flush),
    .ex_stall (ex_stall),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sbu;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sbu = ub;
    p   = '0;
    case (f)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * sbu;
      3'd3: p = ua * ub;
      default: ;
    endcase
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (!f[0]) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 100));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op with start held until done (the pipeline keeps presenting
  // it), then check latency, stall cycles, result and rd_out.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit nowait, input bit hold);
    int          done_at;
    int          stalls;
    int          exp_lat;
    logic [31:0] got_res;
    logic [4:0]  got_rd;
    logic [31:0] exp_res;
    exp_res = model(f, a, b);
    exp_lat = is_special(f, a, b) ? 1 : 34;
    got_res = '0;
    got_rd  = '0;
    if (!nowait) @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd = r; flush = 1'b0;
    #1;
    stalls  = ex_stall ? 1 : 0;
    done_at = -1;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      @(negedge clk);
      if (ex_stall) stalls++;
      if (done) begin
        done_at = k;
        got_res = result;
        got_rd  = rd_out;
        if (!hold) start = 1'b0;
      end
    end
    if (hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    check($sformatf("latency f3=%0d", f), 64'(done_at), 64'(exp_lat));
    check($sformatf("stall_cycles f3=%0d", f), 64'(stalls), 64'(exp_lat));
    check($sformatf("result f3=%0d a=%h b=%h", f, a, b), 64'(got_res), 64'(exp_res));
    check("rd_out", 64'(got_rd), 64'(r));
  endtask

  initial begin
    logic [31:0] prev;
    int          pulses;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
    rd = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_stall", 64'(ex_stall), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_rd_out", 64'(rd_out), 64'(0));
    rst = 1'b0;

    // Directed cases.
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 0, 0);
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4, 0, 0);
    do_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 0, 0);
    do_op(3'd5, 32'd20, 32'd3, 5'd7, 0, 0);
    do_op(3'd7, 32'd20, 32'd3, 5'd8, 0, 0);
    do_op(3'd5, 32'd5, 32'd0, 5'd9, 0, 0);
    do_op(3'd7, 32'd5, 32'd0, 5'd10, 0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 0);

    // Flush in cycle N+10, then a new MUL accepted in N+11.
    prev = result;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'h1234_5678; rs2_data = 32'h9; rd = 5'd13;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    flush = 1'b1;
    #1;
    check("flush_stall_comb", 64'(ex_stall), 64'(0));
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    if (done) pulses++;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_stall", 64'(ex_stall), 64'(0));
    check("flush_no_done", 64'(pulses), 64'(0));
    check("flush_result_kept", 64'(result), 64'(prev));
    do_op(3'd0, 32'hFFFF_FFF0, 32'd3, 5'd14, 1, 0);

    // Flush has priority over start in IDLE, even for a special case.
    prev = result;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1_data = 32'd1; rs2_data = 32'd0; rd = 5'd15;
    #1;
    check("flush_start_stall", 64'(ex_stall), 64'(0));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'(0));
    check("flush_start_done", 64'(done), 64'(0));
    @(negedge clk);
    check("flush_start_result", 64'(result), 64'(prev));

    // Reset during CALC clears every output.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd1; rs1_data = 32'h7FFF_FFFF; rs2_data = 32'h7; rd = 5'd16;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_calc_done", 64'(done), 64'(0));
    check("rst_calc_busy", 64'(busy), 64'(0));
    check("rst_calc_stall", 64'(ex_stall), 64'(0));
    check("rst_calc_result", 64'(result), 64'(0));
    check("rst_calc_rd_out", 64'(rd_out), 64'(0));
    rst = 1'b0;

    // start held through DONE must not re-issue the same op.
    do_op(3'd0, 32'd11, 32'd13, 5'd17, 0, 1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("hold_single_done", 64'(pulses), 64'(0));
    check("hold_idle_busy", 64'(busy), 64'(0));

    // Back-to-back ops with no idle gap, then random ops.
    do_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5'd18, 0, 0);
    do_op(3'd6, 32'd100, 32'hFFFF_FFF9, 5'd19, 0, 0);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      do_op(f, a, b, 5'($urandom_range(0, 31)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
